// File: rtl/vga_shader_pkg.sv
// Shared constants for the VGA shader path: 800x600 timing, coordinate
// fixed-point format, per-pixel/per-line steps and the scheduler state encoding.
package vga_shader_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_TOTAL  = 1056;
    localparam int V_ACTIVE = 600;
    localparam int V_TOTAL  = 628;

    localparam int COORD_W  = 18;
    localparam int ITER_W   = 8;
    localparam int FRAC     = 2;
    localparam int ACC_W    = COORD_W + FRAC;

    // Accumulator constants in Q.FRAC milli-units
    localparam logic signed [ACC_W-1:0] X0 = ACC_W'(-6916);
    localparam logic signed [ACC_W-1:0] DX = ACC_W'(10);
    localparam logic signed [ACC_W-1:0] Y0 = ACC_W'(-3160);
    localparam logic signed [ACC_W-1:0] DY = ACC_W'(13);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/shader_coord_stepper.sv
// x/y coordinate accumulators in Q.FRAC; outputs are the floored integer
// milli-unit coordinates presented to the iteration core.
module shader_coord_stepper
    import vga_shader_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load_x,
    input  logic               step_x,
    input  logic               load_y,
    input  logic               step_y,
    output logic [COORD_W-1:0] coord_x,
    output logic [COORD_W-1:0] coord_y
);

    logic signed [ACC_W-1:0] x_acc;
    logic signed [ACC_W-1:0] y_acc;

    // Arithmetic shift drops the fraction rounding toward minus infinity
    function automatic logic [COORD_W-1:0] floor_coord(input logic signed [ACC_W-1:0] acc);
        return COORD_W'(acc >>> FRAC);
    endfunction

    // x restarts at the left edge per job and advances one pixel per result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_acc <= X0;
        end else if (load_x) begin
            x_acc <= X0;
        end else if (step_x) begin
            x_acc <= x_acc + DX;
        end
    end

    // y reloads for line 0 and advances one line per subsequent job
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_acc <= Y0;
        end else if (load_y) begin
            y_acc <= Y0;
        end else if (step_y) begin
            y_acc <= y_acc + DY;
        end
    end

    assign coord_x = floor_coord(x_acc);
    assign coord_y = floor_coord(y_acc);

endmodule

// File: rtl/shader_line_scheduler.sv
// Runs the fractal iteration core one scanline ahead of VGA scanout: issues
// one coordinate request at a time, writes results into the back bank of a
// ping-pong line buffer, and flips banks at each visible line boundary.
module shader_line_scheduler
    import vga_shader_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pix_en,
    input  logic [11:0]        hcount,
    input  logic [11:0]        vcount,
    output logic               core_req_valid,
    input  logic               core_req_ready,
    output logic [COORD_W-1:0] core_req_x,
    output logic [COORD_W-1:0] core_req_y,
    input  logic               core_resp_valid,
    input  logic [ITER_W-1:0]  core_resp_iter,
    output logic               buf_we,
    output logic [9:0]         buf_waddr,
    output logic [ITER_W-1:0]  buf_wdata,
    output logic               buf_wbank,
    output logic               disp_bank,
    output logic               line_done,
    output logic               overrun,
    input  logic               overrun_clr
);

    sched_state_t state;
    logic [9:0]   index;
    logic         pending;

    logic         line_tick;
    logic [11:0]  next_line;
    logic         bank_flip;
    logic         job_first;
    logic         job_next;
    logic         job_go;
    logic         accept;
    logic         capture;
    logic         last_pix;
    logic         deadline_miss;
    logic         pend_now;

    assign line_tick     = pix_en && (hcount == 12'(H_TOTAL - 1));
    assign next_line     = (vcount == 12'(V_TOTAL - 1)) ? 12'd0 : vcount + 12'd1;
    assign bank_flip     = line_tick && (next_line < 12'(V_ACTIVE));
    // Line 0 is rendered during the last blanking line; other lines one ahead
    assign job_first     = next_line == 12'(V_TOTAL - 1);
    assign job_next      = next_line < 12'(V_ACTIVE - 1);
    assign job_go        = line_tick && (job_first || job_next);
    assign accept        = (state == ST_ISSUE) && core_req_valid && core_req_ready;
    // A result landing on the deadline tick belongs to the aborted job
    assign capture       = (state == ST_WAIT) && core_resp_valid && !line_tick;
    assign last_pix      = index == 10'(H_ACTIVE - 1);
    assign deadline_miss = line_tick && (state != ST_IDLE);
    // Job waiting to run once the datapath is free, including one starting now
    assign pend_now      = line_tick ? job_go : pending;

    shader_coord_stepper u_stepper (
        .clock   (clock),
        .reset_n (reset_n),
        .load_x  (job_go),
        .step_x  (capture),
        .load_y  (job_go && job_first),
        .step_y  (job_go && job_next),
        .coord_x (core_req_x),
        .coord_y (core_req_y)
    );

    // Display bank flip, write-bank tracking and sticky deadline flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_bank <= 1'b0;
            buf_wbank <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bank_flip) begin
                disp_bank <= ~disp_bank;
            end
            buf_wbank <= bank_flip ? disp_bank : ~disp_bank;
            if (deadline_miss) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Request/response sequencing, pixel index and line-buffer write port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            core_req_valid <= 1'b0;
            pending        <= 1'b0;
            index          <= '0;
            buf_we         <= 1'b0;
            buf_waddr      <= '0;
            buf_wdata      <= '0;
            line_done      <= 1'b0;
        end else begin
            buf_we    <= 1'b0;
            line_done <= 1'b0;
            if (job_go) begin
                index <= '0;
            end else if (capture) begin
                index <= index + 10'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (pend_now) begin
                        state          <= ST_ISSUE;
                        core_req_valid <= 1'b1;
                    end
                    pending <= 1'b0;
                end
                ST_ISSUE: begin
                    if (line_tick) begin
                        // Unaccepted request is withdrawn; an accepted one must be drained
                        core_req_valid <= 1'b0;
                        pending        <= job_go;
                        state          <= accept ? ST_DRAIN : ST_IDLE;
                    end else if (accept) begin
                        core_req_valid <= 1'b0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (line_tick) begin
                        // Coincident result consumes the outstanding request, nothing to drain
                        pending <= job_go;
                        state   <= core_resp_valid ? ST_IDLE : ST_DRAIN;
                    end else if (capture) begin
                        buf_we    <= 1'b1;
                        buf_waddr <= index;
                        buf_wdata <= core_resp_iter;
                        if (last_pix) begin
                            line_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            core_req_valid <= 1'b1;
                            state          <= ST_ISSUE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (core_resp_valid) begin
                        pending <= 1'b0;
                        if (pend_now) begin
                            core_req_valid <= 1'b1;
                            state          <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (line_tick) begin
                        pending <= job_go;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    core_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
